// File: rtl/ring_link_arbiter.sv
// Three-way round-robin arbiter for a ring node's outbound link: single-entry
// per-source buffers, a registered valid/ready output stage, and looped-flit discard.
module ring_link_arbiter #(
  parameter int                          NODE_IP_BITWIDTH = 3,
  parameter logic [NODE_IP_BITWIDTH-1:0] NODE_IP          = '0,
  parameter int                          DATA_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                in_valid,
  input  logic [3*DATA_WIDTH-1:0]   in_data,
  output logic [2:0]                in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [1:0]                out_src,
  input  logic                      out_ready,
  output logic [7:0]                drop_count
);

  localparam int ORIG_LSB = DATA_WIDTH - 2*NODE_IP_BITWIDTH;

  function automatic logic [1:0] next_idx(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, n};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  logic [2:0]            buf_full_p0;
  logic [DATA_WIDTH-1:0] buf_data_p0 [3];
  logic [2:0]            rdy_p0;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [1:0]            src_p1;
  logic [1:0]            last_grant;
  logic [7:0]            drop_cnt;

  logic [DATA_WIDTH-1:0] flit [3];
  logic [2:0]            accept;
  logic [2:0]            discard;
  logic [2:0]            store;
  logic [2:0]            grant;
  logic [2:0]            buf_full_nxt;
  logic [1:0]            win;
  logic [1:0]            drop_inc;
  logic                  any_full;
  logic                  stage_free;

  // Input side: accept, loop discard, buffer occupancy
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flit[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    accept  = in_valid & rdy_p0;
    discard = 3'b000;
    for (int i = 1; i < 3; i++) begin
      discard[i] = accept[i] & (flit[i][ORIG_LSB +: NODE_IP_BITWIDTH] == NODE_IP);
    end
    store    = accept & ~discard;
    drop_inc = {1'b0, discard[1]} + {1'b0, discard[2]};
  end

  // Round-robin pick starting just after the previous winner
  always_comb begin
    logic [1:0] idx;
    win      = last_grant;
    any_full = 1'b0;
    idx      = next_idx(last_grant);
    for (int k = 0; k < 3; k++) begin
      if (!any_full && buf_full_p0[idx]) begin
        any_full = 1'b1;
        win      = idx;
      end
      idx = next_idx(idx);
    end
    stage_free   = ~vld_p1 | out_ready;
    grant        = (stage_free && any_full) ? (3'b001 << win) : 3'b000;
    buf_full_nxt = (buf_full_p0 & ~grant) | store;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full_p0 <= 3'b000;
      rdy_p0      <= 3'b000;
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      src_p1      <= 2'd0;
      last_grant  <= 2'd2;
      drop_cnt    <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        buf_data_p0[i] <= '0;
      end
    end else begin
      buf_full_p0 <= buf_full_nxt;
      // Ready is the registered complement of next occupancy: no path from out_ready
      rdy_p0      <= ~buf_full_nxt;
      for (int i = 0; i < 3; i++) begin
        if (store[i]) buf_data_p0[i] <= flit[i];
      end
      // Output stage
      if (stage_free) begin
        if (any_full) begin
          vld_p1     <= 1'b1;
          data_p1    <= buf_data_p0[win];
          src_p1     <= win;
          last_grant <= win;
        end else begin
          vld_p1 <= 1'b0;
        end
      end
      drop_cnt <= sat_add(drop_cnt, drop_inc);
    end
  end

  assign in_ready   = rdy_p0;
  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_src    = src_p1;
  assign drop_count = drop_cnt;

endmodule

// File: tb/tb_ring_link_arbiter.sv
// Directed self-checking bench for ring_link_arbiter with hand-computed expectations.
module tb_ring_link_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      in_valid;
  logic [3*DW-1:0] in_data;
  logic [2:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic [7:0]      drop_count;

  int checks = 0;
  int errors = 0;
  int seq [3];

  ring_link_arbiter #(.NODE_IP_BITWIDTH(3), .NODE_IP(3'b000), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Flit tagged with source and sequence; origin = src+1 so it is never a loop flit
  function automatic logic [31:0] mkflit(input int src, input int s);
    logic [2:0] o;
    logic [7:0] a;
    logic [7:0] b;
    o = 3'(src + 1);
    a = 8'(src);
    b = 8'(s);
    return {3'b111, o, 10'h000, a, b};
  endfunction

  task automatic load_seq_data();
    for (int i = 0; i < 3; i++) in_data[i*DW +: DW] = mkflit(i, seq[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One edge; sources accepted on that edge advance to their next flit
  task automatic tick_src();
    logic [2:0] acc;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i]) seq[i]++;
    load_seq_data();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 3'b000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) seq[i] = 0;
    load_seq_data();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 3'b000;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check("rst_in_ready",   32'(in_ready),   32'h0);
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_out_data",   out_data,        32'h0);
    check("rst_out_src",    32'(out_src),    32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);

    // Single local flit
    do_reset();
    check("rdy_after_release", 32'(in_ready), 32'h7);
    in_valid = 3'b001;
    in_data[0 +: DW] = 32'h2A000001;
    step();
    in_valid = 3'b000;
    check("single_vld_e0",   32'(out_valid), 32'h0);
    check("single_rdy_e0",   32'(in_ready),  32'h6);
    step();
    check("single_vld_e1",   32'(out_valid), 32'h1);
    check("single_data",     out_data,       32'h2A000001);
    check("single_src",      32'(out_src),   32'h0);
    check("single_drop",     32'(drop_count), 32'h0);
    check("single_rdy_e1",   32'(in_ready),  32'h7);
    step();
    check("single_drained",  32'(out_valid), 32'h0);

    // Round robin with all sources streaming
    do_reset();
    in_valid = 3'b111;
    tick_src();
    check("rr_vld_e0", 32'(out_valid), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      tick_src();
      check("rr_vld",  32'(out_valid), 32'h1);
      check("rr_src",  32'(out_src),   32'((k - 1) % 3));
      check("rr_data", out_data,       mkflit((k - 1) % 3, (k - 1) / 3));
    end
    in_valid = 3'b000;

    // Loop discard on source 1, same flit accepted normally on source 0
    do_reset();
    in_valid = 3'b010;
    in_data[DW +: DW] = 32'h60000000;
    step();
    in_valid = 3'b000;
    check("loop_rdy",   32'(in_ready),   32'h7);
    check("loop_drop",  32'(drop_count), 32'h1);
    check("loop_vld0",  32'(out_valid),  32'h0);
    step();
    check("loop_vld1",  32'(out_valid),  32'h0);
    in_valid = 3'b001;
    in_data[0 +: DW] = 32'h60000000;
    step();
    in_valid = 3'b000;
    step();
    check("loop_src0_vld",  32'(out_valid),  32'h1);
    check("loop_src0_data", out_data,        32'h60000000);
    check("loop_src0_src",  32'(out_src),    32'h0);
    check("loop_src0_drop", 32'(drop_count), 32'h1);

    // Dual discard saturation
    do_reset();
    in_valid = 3'b110;
    in_data[DW +: DW]   = 32'h60000000;
    in_data[2*DW +: DW] = 32'h60000000;
    for (int n = 1; n <= 130; n++) begin
      step();
      if (n == 1)   check("sat_n1",   32'(drop_count), 32'd2);
      if (n == 127) check("sat_n127", 32'(drop_count), 32'd254);
      if (n == 128) check("sat_n128", 32'(drop_count), 32'd255);
    end
    check("sat_hold", 32'(drop_count), 32'd255);
    check("sat_vld",  32'(out_valid),  32'h0);
    check("sat_rdy",  32'(in_ready),   32'h7);
    in_valid = 3'b000;

    // Backpressure then release
    do_reset();
    out_ready = 1'b0;
    in_valid  = 3'b111;
    for (int c = 1; c <= 10; c++) begin
      tick_src();
      if (c >= 3) begin
        check("bp_rdy",  32'(in_ready),  32'h0);
        check("bp_vld",  32'(out_valid), 32'h1);
        check("bp_data", out_data,       mkflit(0, 0));
        check("bp_src",  32'(out_src),   32'h0);
      end
    end
    in_valid  = 3'b000;
    out_ready = 1'b1;
    check("drain0_data", out_data, mkflit(0, 0));
    step();
    check("drain1_vld",  32'(out_valid), 32'h1);
    check("drain1_data", out_data,       mkflit(1, 0));
    step();
    check("drain2_vld",  32'(out_valid), 32'h1);
    check("drain2_data", out_data,       mkflit(2, 0));
    step();
    check("drain3_vld",  32'(out_valid), 32'h1);
    check("drain3_data", out_data,       mkflit(0, 1));
    step();
    check("drain_empty", 32'(out_valid), 32'h0);
    check("drain_rdy",   32'(in_ready),  32'h7);

    // Reset asserted mid-transfer with buffers full; first drop one loop flit
    do_reset();
    in_valid = 3'b010;
    in_data[DW +: DW] = 32'h60000000;
    step();
    out_ready = 1'b0;
    in_valid  = 3'b111;
    load_seq_data();
    repeat (4) tick_src();
    check("pre_rst_vld",  32'(out_valid),  32'h1);
    check("pre_rst_drop", 32'(drop_count), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_vld",  32'(out_valid),  32'h0);
    check("mid_rst_drop", 32'(drop_count), 32'h0);
    check("mid_rst_rdy",  32'(in_ready),   32'h0);
    check("mid_rst_data", out_data,        32'h0);
    in_valid  = 3'b000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) seq[i] = 0;
    load_seq_data();
    @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    check("post_rst_rdy", 32'(in_ready), 32'h7);
    in_valid = 3'b111;
    tick_src();
    check("post_rst_vld0", 32'(out_valid), 32'h0);
    tick_src();
    in_valid = 3'b000;
    check("post_rst_vld1", 32'(out_valid), 32'h1);
    check("post_rst_src",  32'(out_src),   32'h0);
    check("post_rst_data", out_data,       mkflit(0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
